// File: rtl/adc_dual_scan_sequencer.sv
// Autonomous dual-core ADC scan sequencer. Walks a programmable slot table,
// issues one command per slot to the selected core, waits for the matching
// response (or a timeout) and stores the 12-bit sample in a per-slot bank.
module adc_dual_scan_sequencer #(
  parameter  int NUM_SLOTS = 8,
  parameter  int TIMEOUT   = 255,
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clock_clk,
  input  logic              reset_sink_reset_n,
  input  logic              enable,
  input  logic [SLOT_W-1:0] last_slot,
  input  logic              cfg_wr,
  input  logic [SLOT_W-1:0] cfg_addr,
  input  logic [5:0]        cfg_wdata,
  output logic              cmd1_valid,
  output logic              cmd1_sop,
  output logic              cmd1_eop,
  output logic [4:0]        cmd1_channel,
  input  logic              cmd1_ready,
  output logic              cmd2_valid,
  output logic              cmd2_sop,
  output logic              cmd2_eop,
  output logic [4:0]        cmd2_channel,
  input  logic              cmd2_ready,
  input  logic              rsp1_valid,
  input  logic [4:0]        rsp1_channel,
  input  logic [11:0]       rsp1_data,
  input  logic              rsp2_valid,
  input  logic [4:0]        rsp2_channel,
  input  logic [11:0]       rsp2_data,
  input  logic [SLOT_W-1:0] rd_addr,
  output logic [11:0]       rd_data,
  output logic              rd_fresh,
  output logic              busy,
  output logic              scan_done,
  output logic              err_mismatch,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_NEXT  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SLOT_W-1:0]   last_q, last_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [5:0]          tbl_q  [NUM_SLOTS];
  logic [11:0]         bank_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] fresh_q;
  logic                err_mm_q, err_to_q;
  logic [11:0]         rd_data_q;
  logic                rd_fresh_q;

  // Current slot decode; entry bit 5 selects core 2.
  logic [5:0]  cur_ent;
  logic        cur_c2;
  logic [4:0]  cur_ch;
  logic        issuing, cmd_fire;
  logic        rsp_v, rsp_ok, rsp_bad, tmo, last_hit, restart;
  logic [4:0]  rsp_ch;
  logic [11:0] rsp_dat;

  assign cur_ent  = tbl_q[slot_q];
  assign cur_c2   = cur_ent[5];
  assign cur_ch   = cur_ent[4:0];
  assign issuing  = (state_q == S_ISSUE);
  assign cmd_fire = issuing && (cur_c2 ? cmd2_ready : cmd1_ready);

  // Only the commanded core's response stream is looked at, and only in WAIT.
  assign rsp_v    = (state_q == S_WAIT) && (cur_c2 ? rsp2_valid : rsp1_valid);
  assign rsp_ch   = cur_c2 ? rsp2_channel : rsp1_channel;
  assign rsp_dat  = cur_c2 ? rsp2_data    : rsp1_data;
  assign rsp_ok   = rsp_v && (rsp_ch == cur_ch);
  assign rsp_bad  = rsp_v && (rsp_ch != cur_ch);
  // A response arriving on the expiry cycle beats the timeout.
  assign tmo      = (state_q == S_WAIT) && !rsp_v && (timer_q == TMR_W'(TIMEOUT - 1));
  assign last_hit = (slot_q == last_slot);
  assign restart  = enable && ((state_q == S_IDLE) || ((state_q == S_NEXT) && last_hit));

  // Command outputs are decoded from registered state; fields zero when idle.
  assign cmd1_valid   = issuing && !cur_c2;
  assign cmd2_valid   = issuing &&  cur_c2;
  assign cmd1_channel = cmd1_valid ? cur_ch : 5'd0;
  assign cmd2_channel = cmd2_valid ? cur_ch : 5'd0;
  assign cmd1_sop     = cmd1_valid && (slot_q == '0);
  assign cmd2_sop     = cmd2_valid && (slot_q == '0);
  assign cmd1_eop     = cmd1_valid && (slot_q == last_q);
  assign cmd2_eop     = cmd2_valid && (slot_q == last_q);

  assign busy         = (state_q != S_IDLE);
  assign scan_done    = (state_q == S_NEXT) && last_hit;
  assign err_mismatch = err_mm_q;
  assign err_timeout  = err_to_q;
  assign rd_data      = rd_data_q;
  assign rd_fresh     = rd_fresh_q;

  // Next-state logic for the scan FSM, slot pointer and WAIT timer.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: if (enable) begin
        state_d = S_ISSUE;
        slot_d  = '0;
        last_d  = last_slot;
      end
      S_ISSUE: if (cmd_fire) begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (rsp_v || tmo) state_d = S_NEXT;
        else              timer_d = timer_q + TMR_W'(1);
      end
      default: begin
        last_d = last_slot;
        if (!last_hit) begin
          slot_d  = slot_q + SLOT_W'(1);
          state_d = S_ISSUE;
        end else begin
          slot_d  = '0;
          state_d = enable ? S_ISSUE : S_IDLE;
        end
      end
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clock_clk) begin
    if (!reset_sink_reset_n) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      last_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // Slot table (writable only while idle), result bank and fresh bits.
  always_ff @(posedge clock_clk) begin
    if (!reset_sink_reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tbl_q[i]  <= '0;
        bank_q[i] <= '0;
      end
      fresh_q <= '0;
    end else begin
      if (cfg_wr && (state_q == S_IDLE)) tbl_q[cfg_addr] <= cfg_wdata;
      if (rsp_ok) bank_q[slot_q] <= rsp_dat;
      if (restart)     fresh_q         <= '0;
      else if (rsp_ok) fresh_q[slot_q] <= 1'b1;
    end
  end

  // Sticky error flags; a set event outranks a simultaneous clear.
  always_ff @(posedge clock_clk) begin
    if (!reset_sink_reset_n) begin
      err_mm_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      if (rsp_bad)      err_mm_q <= 1'b1;
      else if (err_clr) err_mm_q <= 1'b0;
      if (tmo)          err_to_q <= 1'b1;
      else if (err_clr) err_to_q <= 1'b0;
    end
  end

  // Registered readout; a same-cycle store is seen on the following read.
  always_ff @(posedge clock_clk) begin
    if (!reset_sink_reset_n) begin
      rd_data_q  <= '0;
      rd_fresh_q <= 1'b0;
    end else begin
      rd_data_q  <= bank_q[rd_addr];
      rd_fresh_q <= fresh_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_adc_dual_scan_sequencer.sv
// Scoreboard bench: expected commands are queued by the stimulus and popped
// by a monitor on every command handshake; flags and readout checked directly.
module tb_adc_dual_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  last_slot;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [5:0]  cfg_wdata;
  logic        cmd1_valid, cmd1_sop, cmd1_eop, cmd1_ready;
  logic [4:0]  cmd1_channel;
  logic        cmd2_valid, cmd2_sop, cmd2_eop, cmd2_ready;
  logic [4:0]  cmd2_channel;
  logic        rsp1_valid, rsp2_valid;
  logic [4:0]  rsp1_channel, rsp2_channel;
  logic [11:0] rsp1_data, rsp2_data;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic        rd_fresh, busy, scan_done, err_mismatch, err_timeout, err_clr;

  always #5 clk = ~clk;

  adc_dual_scan_sequencer dut (
    .clock_clk(clk), .reset_sink_reset_n(rst_n), .enable(enable),
    .last_slot(last_slot), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cmd1_valid(cmd1_valid), .cmd1_sop(cmd1_sop), .cmd1_eop(cmd1_eop),
    .cmd1_channel(cmd1_channel), .cmd1_ready(cmd1_ready),
    .cmd2_valid(cmd2_valid), .cmd2_sop(cmd2_sop), .cmd2_eop(cmd2_eop),
    .cmd2_channel(cmd2_channel), .cmd2_ready(cmd2_ready),
    .rsp1_valid(rsp1_valid), .rsp1_channel(rsp1_channel), .rsp1_data(rsp1_data),
    .rsp2_valid(rsp2_valid), .rsp2_channel(rsp2_channel), .rsp2_data(rsp2_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_fresh(rd_fresh), .busy(busy),
    .scan_done(scan_done), .err_mismatch(err_mismatch), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  typedef struct {
    logic       c2;
    logic [4:0] ch;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic c2, input logic [4:0] ch, input logic sop, input logic eop);
    exp_t e;
    e.c2 = c2; e.ch = ch; e.sop = sop; e.eop = eop;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every accepted command against the head of the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((cmd1_valid && cmd1_ready) || (cmd2_valid && cmd2_ready)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got core2=%0b ch=%0d want none", cmd2_valid, cmd1_valid ? cmd1_channel : cmd2_channel);
        end else begin
          exp_t e;
          logic [7:0] act, want;
          e = exp_q.pop_front();
          if (cmd1_valid) act = {cmd2_valid, 1'b0, cmd1_channel, cmd1_sop} ^ 8'h00;
          else            act = {1'b1, cmd1_valid, cmd2_channel, cmd2_sop};
          act  = cmd1_valid ? {1'b0, cmd2_valid, cmd1_channel, cmd1_sop}
                            : {1'b1, cmd1_valid, cmd2_channel, cmd2_sop};
          want = {e.c2, 1'b0, e.ch, e.sop};
          if (act !== want || (cmd1_valid ? cmd1_eop : cmd2_eop) !== e.eop) begin
            errors++;
            $display("FAIL cmd_fields: got {c2,other,ch,sop}=%0h eop=%0b want %0h eop=%0b",
                     act, cmd1_valid ? cmd1_eop : cmd2_eop, want, e.eop);
          end
        end
      end
      if (scan_done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic c2, input logic [4:0] ch);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = {c2, ch};
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_en();
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  // Wait (bounded) for a handshake on the given core; returns just after that edge.
  task automatic wait_hs(input logic c2);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (c2 ? (cmd2_valid && cmd2_ready) : (cmd1_valid && cmd1_ready)) break;
      n++;
    end
    check("hs_seen", (n < 100), 1);
    step();
    check("valid_drop", c2 ? cmd2_valid : cmd1_valid, 0);
  endtask

  task automatic respond(input logic c2, input logic [4:0] ch, input logic [11:0] d,
                         input int dly, input logic clr);
    repeat (dly) step();
    if (c2) begin rsp2_valid = 1'b1; rsp2_channel = ch; rsp2_data = d; end
    else    begin rsp1_valid = 1'b1; rsp1_channel = ch; rsp1_data = d; end
    err_clr = clr;
    step();
    rsp1_valid = 1'b0; rsp2_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("back_to_idle", (n < 50), 1);
  endtask

  task automatic read_chk(input logic [2:0] a, input logic [11:0] d, input logic f);
    rd_addr = a;
    step();
    check("rd_data", rd_data, d);
    check("rd_fresh", rd_fresh, f);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  initial begin
    int stable, cnt;
    rst_n = 1'b0; enable = 1'b0; last_slot = '0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cmd1_ready = 1'b1; cmd2_ready = 1'b1; err_clr = 1'b0; rd_addr = '0;
    rsp1_valid = 1'b0; rsp1_channel = '0; rsp1_data = '0;
    rsp2_valid = 1'b0; rsp2_channel = '0; rsp2_data = '0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", {cmd1_valid, cmd2_valid}, 0);
    check("rst_outs", {scan_done, rd_fresh, err_mismatch, err_timeout}, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    step();

    // Two-slot scan across both cores.
    cfg(3'd0, 1'b0, 5'd3);
    cfg(3'd1, 1'b1, 5'd5);
    last_slot = 3'd1;
    push(1'b0, 5'd3, 1'b1, 1'b0);
    push(1'b1, 5'd5, 1'b0, 1'b1);
    pulse_en();
    check("busy_after_en", busy, 1);
    check("cmd1_valid_after_en", cmd1_valid, 1);
    wait_hs(1'b0);
    respond(1'b0, 5'd3, 12'h123, 1, 1'b0);
    wait_hs(1'b1);
    respond(1'b1, 5'd5, 12'hABC, 1, 1'b0);
    wait_idle();
    check("done_once", done_cnt, 1);
    read_chk(3'd0, 12'h123, 1'b1);
    read_chk(3'd1, 12'hABC, 1'b1);

    // Back-pressure on core 1 for 10 cycles.
    last_slot = 3'd0;
    cmd1_ready = 1'b0;
    push(1'b0, 5'd3, 1'b1, 1'b1);
    pulse_en();
    stable = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd1_valid && cmd1_channel == 5'd3 && cmd1_sop && cmd1_eop && !err_timeout) stable++;
    end
    check("stall_stable", stable, 10);
    step();
    cmd1_ready = 1'b1;
    wait_hs(1'b0);
    respond(1'b0, 5'd3, 12'h456, 0, 1'b0);
    wait_idle();
    read_chk(3'd0, 12'h456, 1'b1);

    // Channel mismatch, clear, and clear colliding with a new mismatch.
    last_slot = 3'd1;
    push(1'b0, 5'd3, 1'b1, 1'b0);
    push(1'b1, 5'd5, 1'b0, 1'b1);
    pulse_en();
    wait_hs(1'b0);
    respond(1'b0, 5'd4, 12'h777, 0, 1'b0);
    check("mismatch_set", err_mismatch, 1);
    wait_hs(1'b1);
    respond(1'b1, 5'd5, 12'h2BC, 0, 1'b0);
    wait_idle();
    read_chk(3'd0, 12'h456, 1'b0);
    read_chk(3'd1, 12'h2BC, 1'b1);
    clear_errs();
    check("mismatch_clr", err_mismatch, 0);
    push(1'b0, 5'd3, 1'b1, 1'b0);
    push(1'b1, 5'd5, 1'b0, 1'b1);
    pulse_en();
    wait_hs(1'b0);
    respond(1'b0, 5'd9, 12'h000, 0, 1'b1);
    check("mismatch_beats_clr", err_mismatch, 1);
    wait_hs(1'b1);
    respond(1'b1, 5'd5, 12'h3BC, 0, 1'b0);
    wait_idle();
    clear_errs();

    // Timeout after 255 WAIT cycles, then a response right at expiry.
    last_slot = 3'd0;
    push(1'b0, 5'd3, 1'b1, 1'b1);
    pulse_en();
    wait_hs(1'b0);
    cnt = 0;
    while (cnt < 400 && !err_timeout) begin
      step();
      cnt++;
    end
    check("timeout_cycles", cnt, 255);
    check("timeout_no_mm", err_mismatch, 0);
    wait_idle();
    clear_errs();
    push(1'b0, 5'd3, 1'b1, 1'b1);
    pulse_en();
    wait_hs(1'b0);
    respond(1'b0, 5'd3, 12'h5A5, 254, 1'b0);
    check("expiry_rsp_no_err", err_timeout, 0);
    wait_idle();
    read_chk(3'd0, 12'h5A5, 1'b1);

    // Continuous one-slot scans on core 2; config writes ignored while busy.
    cfg(3'd0, 1'b1, 5'd7);
    push(1'b1, 5'd7, 1'b1, 1'b1);
    push(1'b1, 5'd7, 1'b1, 1'b1);
    push(1'b1, 5'd7, 1'b1, 1'b1);
    enable = 1'b1;
    wait_hs(1'b1);
    respond(1'b1, 5'd7, 12'h111, 0, 1'b0);
    wait_hs(1'b1);
    read_chk(3'd0, 12'h111, 1'b0);
    cfg(3'd0, 1'b0, 5'd9);
    respond(1'b1, 5'd7, 12'h222, 0, 1'b0);
    wait_hs(1'b1);
    enable = 1'b0;
    respond(1'b1, 5'd7, 12'h333, 0, 1'b0);
    wait_idle();
    read_chk(3'd0, 12'h333, 1'b1);
    check("done_total", done_cnt, 9);

    // Reset in the middle of WAIT; a late response must be ignored.
    push(1'b1, 5'd7, 1'b1, 1'b1);
    pulse_en();
    wait_hs(1'b1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", {cmd1_valid, cmd2_valid}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd", rd_data, 0);
    rst_n = 1'b1;
    respond(1'b1, 5'd7, 12'hFFF, 0, 1'b0);
    check("late_rsp_busy", busy, 0);
    check("late_rsp_err", {err_mismatch, err_timeout}, 0);
    read_chk(3'd0, 12'h000, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
